instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Instruction-fetch request controller between the branch predictor and the ICache. It takes the predicted fetch PC, runs a single-outstanding valid/ready request to the ICache, captures the response for the decoder, and reports the requested, fetching and fetched PCs back to the predictor for its in-pipeline hit checks. On a pipeline flush it discards any stale in-flight response.

## Interface
- Parameters: none; all address widths are `RISCV_ARCH` (64) from `river_cfg_pkg`.
- `i_clk` in 1: CPU clock.
- `i_nrst` in 1: reset, asynchronous, active-low.
- `i_flush_pipeline` in 1: discard in-flight fetch; invalidate PC trackers.
- `i_bp_valid` in 1: predictor fetch request valid.
- `i_bp_pc` in RISCV_ARCH: predicted fetch PC; bits [1:0] are always 0.
- `o_requested_pc` out RISCV_ARCH: PC currently offered to ICache, not yet accepted.
- `o_fetching_pc` out RISCV_ARCH: PC accepted by ICache, response pending.
- `o_mem_req_valid` out 1: ICache request valid.
- `o_mem_addr` out RISCV_ARCH: ICache request address.
- `i_mem_req_ready` in 1: ICache accepts the request.
- `i_mem_data_valid` in 1: ICache response valid.
- `i_mem_data_addr` in RISCV_ARCH: response address.
- `i_mem_data` in 64: response data.
- `i_mem_load_fault` in 1: access fault on the response.
- `i_mem_page_fault` in 1: page fault on the response.
- `o_mem_resp_ready` out 1: ready for a response.
- `o_valid` out 1: one-cycle pulse; new fetched word is available.
- `o_pc` out RISCV_ARCH: fetched PC, also fed to the predictor as its fetched PC.
- `o_instr` out 64: fetched data.
- `o_instr_load_fault` out 1: registered copy of `i_mem_load_fault`.
- `o_instr_page_fault` out 1: registered copy of `i_mem_page_fault`.

## Operation
- States: IDLE, WAIT_ACCEPT, WAIT_RESP. Only one request is ever outstanding.
- IDLE:
  - If `i_bp_valid`: `o_mem_req_valid`<=1, `o_mem_addr`<=`i_bp_pc`, `o_requested_pc`<=`i_bp_pc`, go to WAIT_ACCEPT.
- WAIT_ACCEPT:
  - If `i_mem_req_ready`: `o_mem_req_valid`<=0, `o_fetching_pc`<=`o_mem_addr`, go to WAIT_RESP.
  - Otherwise, if `i_bp_valid`: `o_mem_addr` and `o_requested_pc` follow `i_bp_pc`. The ICache samples the address only in the valid&ready cycle, so the address may change while valid is high.
- WAIT_RESP:
  - `o_mem_resp_ready`=1. This output is combinational: 1 exactly when the state is WAIT_RESP.
  - On `i_mem_data_valid` with the drop flag clear: `o_pc`<=`i_mem_data_addr`, `o_instr`<=`i_mem_data`, faults captured, `o_valid`<=1.
  - Same cycle: if `i_bp_valid`, issue the next request exactly as from IDLE (go to WAIT_ACCEPT); otherwise go to IDLE.
- Flush:
  - On `i_flush_pipeline`: `o_requested_pc`, `o_fetching_pc` and `o_pc`<=all-ones, so predictor comparisons miss; `o_valid`<=0.
  - WAIT_ACCEPT: the request stays valid with its address still following `i_bp_pc`; nothing is dropped.
  - WAIT_RESP without a same-cycle response: set the drop flag.
  - WAIT_RESP with `i_mem_data_valid` in the same cycle: that response is discarded.
  - IDLE: only the trackers are cleared.
- Response with the drop flag set: discarded, no `o_valid`, flag cleared. The next-request rule still applies.
- `i_mem_data_valid` outside WAIT_RESP is ignored.
- Faults are held with `o_pc`/`o_instr` until the next captured response.

## Timing
- Reset values:
  - State IDLE, drop flag 0.
  - `o_mem_req_valid`=0, `o_mem_addr`=0, `o_instr`=0, `o_valid`=0, both fault outputs 0.
  - `o_requested_pc`, `o_fetching_pc` and `o_pc` = all-ones.
- Reset mid-operation returns to these values immediately (asynchronous); any pending response is ignored.
- `i_bp_valid` in IDLE at cycle N -> `o_mem_req_valid`=1 at N+1.
- Valid&ready at cycle M -> `o_fetching_pc` updated and `o_mem_resp_ready`=1 at M+1.
- Response at cycle R -> `o_valid` pulse and `o_pc`/`o_instr` at R+1; the next request is valid at R+1 if `i_bp_valid` was 1 at R.
- Back-to-back throughput with zero-wait ICache: one fetch per 2 cycles (accept, respond).
- All outputs except `o_mem_resp_ready` are registered.

## Test plan
- Single fetch: `i_bp_pc`=0x10000 in IDLE, ready=1, response one cycle later with data 0x0000_0013_0000_0013 -> `o_valid` pulses once with `o_pc`=0x10000, `o_instr` as driven, no fault.
- Backpressure: ready=0 for 3 cycles while `i_bp_pc` steps 0x100 -> 0x104 -> 0x200, then ready=1 -> ICache accepts 0x200; `o_fetching_pc`=0x200; `o_requested_pc` tracked each value with one-cycle lag.
- Flush in WAIT_RESP for 0x300, response arrives 2 cycles later -> no `o_valid`; `o_pc` stays all-ones; next request uses the current `i_bp_pc`=0x400.
- Flush in the same cycle as a response for 0x500 -> response discarded, drop flag stays 0, the next response (0x600) is delivered normally.
- Fault: response for 0x700 with `i_mem_page_fault`=1 -> `o_valid`=1, `o_instr_page_fault`=1, `o_pc`=0x700; cleared on the next good response.
- Async reset asserted in WAIT_RESP -> all outputs at reset values in the same cycle; a response arriving after deassertion produces no `o_valid`.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - single-outstanding instruction fetch request controller
module instr_fetch_ctrl (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_flush_pipeline,
    input  logic        i_bp_valid,
    input  logic [63:0] i_bp_pc,
    output logic [63:0] o_requested_pc,
    output logic [63:0] o_fetching_pc,
    output logic        o_mem_req_valid,
    output logic [63:0] o_mem_addr,
    input  logic        i_mem_req_ready,
    input  logic        i_mem_data_valid,
    input  logic [63:0] i_mem_data_addr,
    input  logic [63:0] i_mem_data,
    input  logic        i_mem_load_fault,
    input  logic        i_mem_page_fault,
    output logic        o_mem_resp_ready,
    output logic        o_valid,
    output logic [63:0] o_pc,
    output logic [63:0] o_instr,
    output logic        o_instr_load_fault,
    output logic        o_instr_page_fault
);
    localparam int RISCV_ARCH = 64;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACCEPT = 2'd1,
        WAIT_RESP   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_drop;
    logic                    r_req_valid;
    logic [RISCV_ARCH-1:0]   r_mem_addr;
    logic [RISCV_ARCH-1:0]   r_requested_pc;
    logic [RISCV_ARCH-1:0]   r_fetching_pc;
    logic [RISCV_ARCH-1:0]   r_pc;
    logic [63:0]             r_instr;
    logic                    r_valid;
    logic                    r_load_fault;
    logic                    r_page_fault;

    logic w_resp;
    logic w_issue;
    logic w_accept;
    logic w_follow;
    logic w_capture;

    // A response only counts while we are waiting for one; stale ones are dropped.
    assign w_resp    = (r_state == WAIT_RESP) && i_mem_data_valid;
    assign w_issue   = ((r_state == IDLE) && i_bp_valid) || (w_resp && i_bp_valid);
    assign w_accept  = (r_state == WAIT_ACCEPT) && i_mem_req_ready;
    assign w_follow  = (r_state == WAIT_ACCEPT) && !i_mem_req_ready && i_bp_valid;
    assign w_capture = w_resp && !r_drop && !i_flush_pipeline;

    // State register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:        if (i_bp_valid) w_state_next = WAIT_ACCEPT;
            WAIT_ACCEPT: if (i_mem_req_ready) w_state_next = WAIT_RESP;
            WAIT_RESP:   if (i_mem_data_valid) w_state_next = i_bp_valid ? WAIT_ACCEPT : IDLE;
            default:     w_state_next = IDLE;
        endcase
    end

    // Response ready is the only combinational output: high for the whole WAIT_RESP state
    always_comb begin
        o_mem_resp_ready = 1'b0;
        if (r_state == WAIT_RESP) o_mem_resp_ready = 1'b1;
    end

    // Request, tracker, capture and drop-flag registers; flush overrides tracker updates
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_drop         <= 1'b0;
            r_req_valid    <= 1'b0;
            r_mem_addr     <= '0;
            r_requested_pc <= '1;
            r_fetching_pc  <= '1;
            r_pc           <= '1;
            r_instr        <= '0;
            r_valid        <= 1'b0;
            r_load_fault   <= 1'b0;
            r_page_fault   <= 1'b0;
        end else begin
            r_valid <= w_capture;

            if (w_issue || w_follow) begin
                r_mem_addr     <= i_bp_pc;
                r_requested_pc <= i_bp_pc;
            end
            if (w_issue) begin
                r_req_valid <= 1'b1;
            end
            if (w_accept) begin
                r_req_valid   <= 1'b0;
                r_fetching_pc <= r_mem_addr;
            end

            if (w_capture) begin
                r_pc         <= i_mem_data_addr;
                r_instr      <= i_mem_data;
                r_load_fault <= i_mem_load_fault;
                r_page_fault <= i_mem_page_fault;
            end

            if (w_resp) begin
                r_drop <= 1'b0;
            end else if ((r_state == WAIT_RESP) && i_flush_pipeline) begin
                r_drop <= 1'b1;
            end

            if (i_flush_pipeline) begin
                r_requested_pc <= '1;
                r_fetching_pc  <= '1;
                r_pc           <= '1;
            end
        end
    end

    assign o_requested_pc     = r_requested_pc;
    assign o_fetching_pc      = r_fetching_pc;
    assign o_mem_req_valid    = r_req_valid;
    assign o_mem_addr         = r_mem_addr;
    assign o_valid            = r_valid;
    assign o_pc               = r_pc;
    assign o_instr            = r_instr;
    assign o_instr_load_fault = r_load_fault;
    assign o_instr_page_fault = r_page_fault;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - directed self-checking bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;
    localparam logic [63:0] ONES = '1;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        flush = 1'b0;
    logic        bp_valid = 1'b0;
    logic [63:0] bp_pc = '0;
    logic [63:0] requested_pc;
    logic [63:0] fetching_pc;
    logic        req_valid;
    logic [63:0] mem_addr;
    logic        req_ready = 1'b0;
    logic        data_valid = 1'b0;
    logic [63:0] data_addr = '0;
    logic [63:0] data = '0;
    logic        load_fault = 1'b0;
    logic        page_fault = 1'b0;
    logic        resp_ready;
    logic        valid;
    logic [63:0] pc;
    logic [63:0] instr;
    logic        instr_load_fault;
    logic        instr_page_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_ctrl dut (
        .i_clk              (clk),
        .i_nrst             (nrst),
        .i_flush_pipeline   (flush),
        .i_bp_valid         (bp_valid),
        .i_bp_pc            (bp_pc),
        .o_requested_pc     (requested_pc),
        .o_fetching_pc      (fetching_pc),
        .o_mem_req_valid    (req_valid),
        .o_mem_addr         (mem_addr),
        .i_mem_req_ready    (req_ready),
        .i_mem_data_valid   (data_valid),
        .i_mem_data_addr    (data_addr),
        .i_mem_data         (data),
        .i_mem_load_fault   (load_fault),
        .i_mem_page_fault   (page_fault),
        .o_mem_resp_ready   (resp_ready),
        .o_valid            (valid),
        .o_pc               (pc),
        .o_instr            (instr),
        .o_instr_load_fault (instr_load_fault),
        .o_instr_page_fault (instr_page_fault)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_accept(input logic [63:0] a);
        bp_valid = 1'b1; bp_pc = a; req_ready = 1'b1;
        step();
        bp_valid = 1'b0;
        step();
    endtask

    task automatic respond(input logic [63:0] a, input logic [63:0] d, input logic lf, input logic pf);
        data_valid = 1'b1; data_addr = a; data = d; load_fault = lf; page_fault = pf;
        step();
        data_valid = 1'b0; load_fault = 1'b0; page_fault = 1'b0;
    endtask

    initial begin
        // Reset values
        step();
        check("rst_req_valid", req_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_requested", requested_pc, ONES);
        check("rst_fetching", fetching_pc, ONES);
        check("rst_pc", pc, ONES);
        check("rst_valid", valid, 0);
        check("rst_instr", instr, 0);
        check("rst_resp_ready", resp_ready, 0);
        nrst = 1'b1;
        step();

        // Single fetch
        bp_valid = 1'b1; bp_pc = 64'h10000; req_ready = 1'b1;
        step();
        check("t1_req_valid", req_valid, 1);
        check("t1_mem_addr", mem_addr, 64'h10000);
        check("t1_requested", requested_pc, 64'h10000);
        bp_valid = 1'b0;
        step();
        check("t1_fetching", fetching_pc, 64'h10000);
        check("t1_req_dropped", req_valid, 0);
        check("t1_resp_ready", resp_ready, 1);
        respond(64'h10000, 64'h0000_0013_0000_0013, 1'b0, 1'b0);
        check("t1_valid", valid, 1);
        check("t1_pc", pc, 64'h10000);
        check("t1_instr", instr, 64'h0000_0013_0000_0013);
        check("t1_pf", instr_page_fault, 0);
        check("t1_lf", instr_load_fault, 0);
        check("t1_idle_ready", resp_ready, 0);
        step();
        check("t1_valid_pulse", valid, 0);

        // Backpressure: address follows the predictor until accepted
        req_ready = 1'b0; bp_valid = 1'b1; bp_pc = 64'h100;
        step();
        check("t2_req0", requested_pc, 64'h100);
        bp_pc = 64'h104;
        step();
        check("t2_req1", requested_pc, 64'h104);
        check("t2_addr1", mem_addr, 64'h104);
        bp_pc = 64'h200;
        step();
        check("t2_req2", requested_pc, 64'h200);
        req_ready = 1'b1; bp_valid = 1'b0;
        step();
        check("t2_fetching", fetching_pc, 64'h200);
        respond(64'h200, 64'hAAAA, 1'b0, 1'b0);
        check("t2_valid", valid, 1);
        check("t2_pc", pc, 64'h200);

        // Flush while waiting for 0x300; late response dropped, next request 0x400
        issue_accept(64'h300);
        check("t3_fetching", fetching_pc, 64'h300);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t3_flush_fetching", fetching_pc, ONES);
        check("t3_flush_pc", pc, ONES);
        check("t3_flush_req", requested_pc, ONES);
        step();
        bp_valid = 1'b1; bp_pc = 64'h400; req_ready = 1'b0;
        respond(64'h300, 64'hBBBB, 1'b0, 1'b0);
        bp_valid = 1'b0;
        check("t3_no_valid", valid, 0);
        check("t3_pc_ones", pc, ONES);
        check("t3_next_valid", req_valid, 1);
        check("t3_next_addr", mem_addr, 64'h400);
        req_ready = 1'b1;
        step();
        respond(64'h400, 64'hCCCC, 1'b0, 1'b0);
        check("t3_after_valid", valid, 1);
        check("t3_after_pc", pc, 64'h400);

        // Flush coincident with response for 0x500; next request 0x600 delivered
        issue_accept(64'h500);
        flush = 1'b1; bp_valid = 1'b1; bp_pc = 64'h600; req_ready = 1'b0;
        respond(64'h500, 64'hDDDD, 1'b0, 1'b0);
        flush = 1'b0; bp_valid = 1'b0;
        check("t4_no_valid", valid, 0);
        check("t4_pc_ones", pc, ONES);
        check("t4_next_addr", mem_addr, 64'h600);
        req_ready = 1'b1;
        step();
        check("t4_fetching", fetching_pc, 64'h600);
        respond(64'h600, 64'hEEEE, 1'b0, 1'b0);
        check("t4_valid", valid, 1);
        check("t4_pc", pc, 64'h600);
        check("t4_instr", instr, 64'hEEEE);

        // Page fault captured, held, then cleared by a good response
        issue_accept(64'h700);
        respond(64'h700, 64'h1111, 1'b0, 1'b1);
        check("t5_valid", valid, 1);
        check("t5_pf", instr_page_fault, 1);
        check("t5_lf", instr_load_fault, 0);
        check("t5_pc", pc, 64'h700);
        step();
        check("t5_pf_held", instr_page_fault, 1);
        issue_accept(64'h704);
        respond(64'h704, 64'h2222, 1'b0, 1'b0);
        check("t5_pf_clear", instr_page_fault, 0);
        check("t5_pc2", pc, 64'h704);

        // Response outside WAIT_RESP is ignored
        respond(64'h708, 64'h3333, 1'b0, 1'b0);
        check("t6_idle_resp", valid, 0);
        check("t6_idle_pc", pc, 64'h704);

        // Async reset in WAIT_RESP
        issue_accept(64'h800);
        check("t7_wait_resp", resp_ready, 1);
        #2;
        nrst = 1'b0;
        #1;
        check("t7_rst_resp_ready", resp_ready, 0);
        check("t7_rst_pc", pc, ONES);
        check("t7_rst_fetching", fetching_pc, ONES);
        check("t7_rst_instr", instr, 0);
        check("t7_rst_pf", instr_page_fault, 0);
        step();
        nrst = 1'b1;
        respond(64'h800, 64'h4444, 1'b0, 1'b0);
        check("t7_no_valid", valid, 0);
        check("t7_pc_ones", pc, ONES);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
